// File: rtl/pll_rst_seq_if.sv
// PLL reset sequencer signal bundle: PLL lock/reset handshake plus the
// status outputs of the sequencer. The master side is the sequencer itself.
interface pll_rst_seq_if;
    logic       pll_lock;
    logic       pll_rst;
    logic       sys_rst;
    logic       lock_ok;
    logic       fail;
    logic [7:0] lost_cnt;

    modport master (
        input  pll_lock,
        output pll_rst,
        output sys_rst,
        output lock_ok,
        output fail,
        output lost_cnt
    );

    modport slave (
        output pll_lock,
        input  pll_rst,
        input  sys_rst,
        input  lock_ok,
        input  fail,
        input  lost_cnt
    );
endinterface

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a filtered lock,
// holds the system reset for a settling period, then releases it. Lock
// timeouts retry the PLL reset up to a budget before latching a failure.
// Optional macro PLL_RST_SEQ_LOSS_CNT_EN enables the saturating lock-loss
// counter; without it lost_cnt is tied to zero.
module pll_rst_seq #(
    parameter int unsigned LOCK_FILT   = 16,
    parameter int unsigned HOLD_CYC    = 1024,
    parameter int unsigned PLL_RST_CYC = 32,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned MAX_RETRY   = 4
) (
    input  logic          clk,
    input  logic          rst,
    pll_rst_seq_if.master bus
);

    localparam int unsigned FILT_W  = $clog2(LOCK_FILT + 1);
    localparam int unsigned HOLD_W  = $clog2(HOLD_CYC + 1);
    localparam int unsigned RST_W   = $clog2(PLL_RST_CYC + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    // Terminal values are one below the parameter: the transition happens on
    // the cycle whose increment would reach the parameter.
    localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILT - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(PLL_RST_CYC - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_HOLD,
        S_RUN,
        S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q;
    logic                lock_s_q;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [RST_W-1:0]    rcnt_q, rcnt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_rst_q, sys_rst_d;
    logic                lock_ok_q, lock_ok_d;
    logic                fail_q, fail_d;

    // Two-flop synchronizer for the asynchronous PLL lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= bus.pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            filt_q    <= '0;
            hold_q    <= '0;
            rcnt_q    <= '0;
            to_q      <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            hold_q    <= hold_d;
            rcnt_q    <= rcnt_d;
            to_q      <= to_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            lock_ok_q <= lock_ok_d;
            fail_q    <= fail_d;
        end
    end

    // Next-state and counter logic; outputs are decoded from the next state
    // so the registered outputs line up with the state register.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        hold_d  = hold_q;
        rcnt_d  = rcnt_q;
        to_d    = to_q;
        retry_d = retry_q;

        unique case (state_q)
            S_PLL_RST: begin
                if (rcnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    rcnt_d  = '0;
                    filt_d  = '0;
                    to_d    = '0;
                end else begin
                    rcnt_d = rcnt_q + RST_W'(1);
                end
            end

            S_WAIT_LOCK: begin
                filt_d = lock_s_q ? filt_q + FILT_W'(1) : '0;
                to_d   = to_q + TO_W'(1);
                // Filter completion takes priority over a coincident timeout.
                if (lock_s_q && (filt_q == FILT_LAST)) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                    filt_d  = '0;
                    to_d    = '0;
                end else if (to_q == TO_LAST) begin
                    retry_d = retry_q + RETRY_W'(1);
                    filt_d  = '0;
                    to_d    = '0;
                    rcnt_d  = '0;
                    state_d = (retry_q == RETRY_LAST) ? S_FAIL : S_PLL_RST;
                end
            end

            S_HOLD: begin
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    filt_d  = '0;
                    to_d    = '0;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    hold_d  = '0;
                    retry_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            S_RUN: begin
                if (!lock_s_q) begin
                    state_d = S_PLL_RST;
                    rcnt_d  = '0;
                end
            end

            S_FAIL: begin
                state_d = S_FAIL;
            end

            default: begin
                state_d = S_PLL_RST;
                rcnt_d  = '0;
            end
        endcase

        pll_rst_d = (state_d == S_PLL_RST);
        sys_rst_d = (state_d != S_RUN);
        lock_ok_d = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    assign bus.pll_rst = pll_rst_q;
    assign bus.sys_rst = sys_rst_q;
    assign bus.lock_ok = lock_ok_q;
    assign bus.fail    = fail_q;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic       lost_evt;
    logic [7:0] lost_q;

    assign lost_evt = (state_q == S_RUN) && !lock_s_q;

    // Saturating count of lock losses observed while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            lost_q <= '0;
        end else if (lost_evt && (lost_q != '1)) begin
            lost_q <= lost_q + 8'd1;
        end
    end

    assign bus.lost_cnt = lost_q;
`else
    assign bus.lost_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Testbench for pll_rst_seq: directed timing scenarios plus randomized lock
// traffic compared against a phase/age reference model.
// Honours PLL_RST_SEQ_LOSS_CNT_EN for the expected lost_cnt value.
module tb_pll_rst_seq;

    localparam int LF  = 4;
    localparam int HC  = 8;
    localparam int PRC = 3;
    localparam int TO  = 20;
    localparam int MR  = 2;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_HOLD = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] obs;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    pll_rst_seq_if bus ();

    pll_rst_seq #(
        .LOCK_FILT  (LF),
        .HOLD_CYC   (HC),
        .PLL_RST_CYC(PRC),
        .TIMEOUT_CYC(TO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.pll_rst, bus.sys_rst, bus.lock_ok, bus.fail, bus.lost_cnt};

    // Reference model: phase, cycles spent in phase, consecutive lock cycles.
    int m_ph, m_age, m_run, m_retry, m_lost;
    bit m_s1, m_s2;

    task automatic model_reset();
        m_ph = P_RST; m_age = 0; m_run = 0; m_retry = 0; m_lost = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit lk);
        int nph;
        bit ls;
        if (r) begin
            model_reset();
            return;
        end
        ls = m_s2;
        nph = m_ph;
        m_age++;
        case (m_ph)
            P_RST:  if (m_age == PRC) nph = P_WAIT;
            P_WAIT: begin
                m_run = ls ? m_run + 1 : 0;
                if (m_run == LF) nph = P_HOLD;
                else if (m_age == TO) begin
                    m_retry++;
                    nph = (m_retry == MR) ? P_FAIL : P_RST;
                end
            end
            P_HOLD: if (!ls) nph = P_WAIT; else if (m_age == HC) nph = P_RUN;
            P_RUN:  if (!ls) begin
                nph = P_RST;
                if (m_lost < 255) m_lost++;
            end
            default: ;
        endcase
        if (nph != m_ph) begin
            m_age = 0;
            m_run = 0;
            if (nph == P_RUN) m_retry = 0;
        end
        m_ph = nph;
        m_s2 = m_s1;
        m_s1 = lk;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 with rst released.
    task automatic do_reset(input bit lk);
        rst = 1'b1;
        bus.pll_lock = lk;
        repeat (3) cyc();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pll_lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            @(negedge clk);
            n_checks++;
            if (obs !== 12'b1100_0000_0000)
                $display("FAIL reset cyc %0d: got %b want %b", k, obs, 12'b1100_0000_0000);
            else n_pass++;
        end
    endtask

    task automatic test_clean_lock();
        logic [11:0] exp;
        do_reset(1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            exp = {k <= 2, k < 15, k >= 15, 1'b0, 8'd0};
            n_checks++;
            if (obs !== exp) $display("FAIL clean_lock cyc %0d: got %b want %b", k, obs, exp);
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_no_lock();
        logic [11:0] exp;
        do_reset(1'b0);
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            exp = {(k < 46) && ((k % 23) < 3), 1'b1, 1'b0, k >= 46, 8'd0};
            n_checks++;
            if (obs !== exp) $display("FAIL no_lock cyc %0d: got %b want %b", k, obs, exp);
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_toggle();
        logic [11:0] exp;
        do_reset(1'b0);
        for (int k = 0; k < 70; k++) begin
            bus.pll_lock = ((k / 3) % 2) == 0;
            @(negedge clk);
            exp = {(k < 46) && ((k % 23) < 3), 1'b1, 1'b0, k >= 46, 8'd0};
            n_checks++;
            if (obs !== exp) $display("FAIL toggle cyc %0d: got %b want %b", k, obs, exp);
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_tie();
        logic [11:0] exp;
        do_reset(1'b0);
        for (int k = 0; k < 40; k++) begin
            bus.pll_lock = (k >= 17);
            @(negedge clk);
            exp = {k <= 2, k < 31, k >= 31, 1'b0, 8'd0};
            n_checks++;
            if (obs !== exp) $display("FAIL filter_vs_timeout cyc %0d: got %b want %b", k, obs, exp);
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_run_loss();
        logic [11:0] exp;
        bit run;
        do_reset(1'b1);
        for (int k = 0; k < 46; k++) begin
            bus.pll_lock = (k != 20);
            @(negedge clk);
            run = ((k >= 15) && (k < 23)) || (k >= 38);
            exp = {(k <= 2) || ((k >= 23) && (k <= 25)), !run, run, 1'b0,
                   (LOSS_EN && (k >= 23)) ? 8'd1 : 8'd0};
            n_checks++;
            if (obs !== exp) $display("FAIL run_loss cyc %0d: got %b want %b", k, obs, exp);
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_hold_glitch();
        logic [11:0] exp;
        do_reset(1'b1);
        for (int k = 0; k < 36; k++) begin
            bus.pll_lock = (k != 12);
            @(negedge clk);
            exp = {k <= 2, k < 27, k >= 27, 1'b0, 8'd0};
            n_checks++;
            if (obs !== exp) $display("FAIL hold_glitch cyc %0d: got %b want %b", k, obs, exp);
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_reset_midway();
        logic [11:0] exp;
        // From RUN after one lock loss.
        do_reset(1'b1);
        for (int k = 0; k < 40; k++) begin
            bus.pll_lock = (k != 16);
            cyc();
        end
        @(negedge clk);
        exp = {1'b0, 1'b0, 1'b1, 1'b0, LOSS_EN ? 8'd1 : 8'd0};
        n_checks++;
        if (obs !== exp) $display("FAIL pre_reset_run: got %b want %b", obs, exp);
        else n_pass++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp = {k <= 2, k < 15, k >= 15, 1'b0, 8'd0};
            n_checks++;
            if (obs !== exp) $display("FAIL reset_from_run cyc %0d: got %b want %b", k, obs, exp);
            else n_pass++;
            cyc();
        end
        // From FAIL.
        do_reset(1'b0);
        repeat (50) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.pll_lock = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp = {k <= 2, k < 15, k >= 15, 1'b0, 8'd0};
            n_checks++;
            if (obs !== exp) $display("FAIL reset_from_fail cyc %0d: got %b want %b", k, obs, exp);
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_saturate();
        logic [8:0] exp;
        int         want;
        do_reset(1'b1);
        repeat (20) cyc();
        for (int i = 1; i <= 300; i++) begin
            bus.pll_lock = 1'b0;
            cyc();
            bus.pll_lock = 1'b1;
            repeat (21) cyc();
            @(negedge clk);
            want = (i > 255) ? 255 : i;
            exp = {1'b1, LOSS_EN ? 8'(want) : 8'd0};
            n_checks++;
            if ({bus.lock_ok, bus.lost_cnt} !== exp)
                $display("FAIL saturate loss %0d: got %b want %b", i, {bus.lock_ok, bus.lost_cnt}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [11:0] exp;
        int          run_left;
        bit          lk;
        run_left = 0;
        lk = 1'b0;
        do_reset(1'b0);
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (run_left == 0) begin
                lk = ~lk;
                if (lk) run_left = $urandom_range(1, 40);
                else if ($urandom_range(0, 9) == 0) run_left = $urandom_range(10, 50);
                else run_left = $urandom_range(1, 4);
            end
            run_left--;
            bus.pll_lock = lk;
            @(negedge clk);
            exp = {m_ph == P_RST, m_ph != P_RUN, m_ph == P_RUN, m_ph == P_FAIL,
                   LOSS_EN ? 8'(m_lost) : 8'd0};
            n_checks++;
            if (obs !== exp) $display("FAIL random cyc %0d: got %b want %b", k, obs, exp);
            else n_pass++;
            model_step(rst, lk);
            cyc();
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.pll_lock = 1'b0;
        test_reset();
        test_clean_lock();
        test_no_lock();
        test_toggle();
        test_tie();
        test_run_loss();
        test_hold_glitch();
        test_reset_midway();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter LOCK_FILT, default 16: consecutive synchronized-lock cycles required before lock is accepted.
REQ-002 Parameter HOLD_CYC, default 1024: cycles sys_rst stays asserted after lock is accepted.
REQ-003 Parameter PLL_RST_CYC, default 32: cycles pll_rst is asserted per PLL reset pulse.
REQ-004 Parameter TIMEOUT_CYC, default 50000: cycles allowed in WAIT_LOCK before the PLL is reset again.
REQ-005 Parameter MAX_RETRY, default 4: consecutive lock timeouts before entering FAIL.
REQ-006 Valid parameter range: every parameter 1..65535; each counter is $clog2(param+1) bits wide.
REQ-007 clk, input, 1: free-running reference clock, the same clock that drives PLL clkin1; one clock domain only.
REQ-008 rst, input, 1: reset, synchronous and active-high.
REQ-009 pll_lock, input, 1: PLL lock flag; asynchronous to clk.
REQ-010 pll_rst, output, 1: drives the PLL RST input.
REQ-011 sys_rst, output, 1: active-high reset for logic clocked by the PLL outputs.
REQ-012 lock_ok, output, 1: high only while in RUN.
REQ-013 fail, output, 1: sticky flag indicating the retry budget is exhausted.
REQ-014 lost_cnt, output, 8: count of lock losses seen in RUN; saturates at 255.

Function
REQ-015 pll_lock SHALL pass through a 2-flop synchronizer; lock_s is the second stage. All decisions use lock_s only.
REQ-016 FSM states SHALL be PLL_RST, WAIT_LOCK, HOLD, RUN and FAIL. All outputs are registered and decoded from the current state.
REQ-017 PLL_RST: pll_rst=1 and sys_rst=1; the state lasts exactly PLL_RST_CYC cycles, then moves to WAIT_LOCK with filter and timeout counters cleared.
REQ-018 WAIT_LOCK: pll_rst=0 and sys_rst=1.
- The filter counter increments while lock_s=1 and clears when lock_s=0.
- When the filter count reaches LOCK_FILT, the state moves to HOLD.
REQ-019 WAIT_LOCK timeout: the timeout counter increments every cycle. When it reaches TIMEOUT_CYC, retry_cnt increments.
- If retry_cnt then equals MAX_RETRY, the state moves to FAIL.
- Otherwise it moves to PLL_RST.
REQ-020 If filter completion and timeout occur in the same cycle, filter completion SHALL win.
REQ-021 HOLD: sys_rst=1. After HOLD_CYC cycles with lock_s=1, the state moves to RUN.
- lock_s=0 at any HOLD cycle, including the last one, returns the state to WAIT_LOCK with counters cleared.
- No PLL reset is issued from HOLD.
REQ-022 RUN: sys_rst=0 and lock_ok=1; retry_cnt clears on entry.
- lock_s=0 moves the state to PLL_RST and increments lost_cnt (saturating).
- sys_rst reasserts on the first PLL_RST cycle.
REQ-023 FAIL: pll_rst=0, sys_rst=1, fail=1. Only rst exits FAIL.
REQ-024 sys_rst SHALL never deassert in any state other than RUN, and SHALL never glitch low during transitions.

Reset
REQ-025 While rst=1 the block SHALL hold: state=PLL_RST, all counters 0, synchronizer flops 0, pll_rst=1, sys_rst=1, lock_ok=0, fail=0, lost_cnt=0.
REQ-026 rst asserted in any state, including mid-HOLD, RUN or FAIL, SHALL take effect at the next clk edge. The PLL_RST_CYC count restarts from zero after rst deasserts.

Configuration
REQ-027 Macro PLL_RST_SEQ_LOSS_CNT_EN controls the loss counter.
- Defined: lost_cnt is implemented per REQ-014 and REQ-022.
- Undefined: the counter logic is removed and lost_cnt is tied to 0.
- All other behaviour is identical in both builds.

Verification
Parameters for all scenarios: LOCK_FILT=4, HOLD_CYC=8, PLL_RST_CYC=3, TIMEOUT_CYC=20, MAX_RETRY=2.
REQ-028 pll_lock=1 constantly, rst released at cycle 0 -> pll_rst high for cycles 0-2, WAIT_LOCK at 3, HOLD at 7, sys_rst falls and lock_ok rises at cycle 15.
REQ-029 pll_lock=0 constantly -> two PLL_RST/WAIT_LOCK rounds of 23 cycles each, then fail=1 at cycle 46; sys_rst stays 1 and pll_rst stays 0 thereafter.
REQ-030 In RUN, drop pll_lock for 1 cycle -> sys_rst=1 and pll_rst=1 three cycles later (2 sync + 1 register); lost_cnt 0->1; full reacquire follows.
REQ-031 In HOLD at hold count 7, drop pll_lock for 1 cycle -> return to WAIT_LOCK, no pll_rst pulse, sys_rst never low.
REQ-032 Toggle pll_lock every 3 cycles in WAIT_LOCK -> filter never completes; timeout and retry occur as in REQ-029.
REQ-033 With PLL_RST_SEQ_LOSS_CNT_EN defined, 300 lock losses in RUN -> lost_cnt saturates at 255. Without the macro, lost_cnt stays 0.
